// File: rtl/op2_pkg.sv
// op2_pkg: shared constants and types for the second-stage adder sequencer.
//   N_OPS    operands per result
//   IN_W     width of one first-stage partial sum
//   SUM_W    width of the adder result
//   IDX_W    operand index width
//   OP_BUS_W flat operand bus width (N_OPS * IN_W)
//   op2_state_t  controller states FILL / WAIT / HOLD
package op2_pkg;
    localparam int N_OPS    = 16;
    localparam int IN_W     = 12;
    localparam int SUM_W    = 16;
    localparam int IDX_W    = 4;
    localparam int OP_BUS_W = N_OPS * IN_W;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } op2_state_t;
endpackage

// File: rtl/op2_ctrl_if.sv
// op2_ctrl_if: upstream (partial-sum) and downstream (result) valid/ready
// handshakes of op2_ctrl.
//   in_valid/in_ready/in_data     upstream word stream
//   out_valid/out_ready/out_data  downstream result
//   master: the side driving words and accepting results
//   slave : the controller
interface op2_ctrl_if;
    import op2_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/op2_bank.sv
// op2_bank: 16 x 12 operand register file with its own write index.
//   clk, rst_n  clock, async active-low reset (clears contents and index)
//   we          write wdata at idx, then advance idx (wraps 15 -> 0)
//   wdata       word to write
//   clr_idx     synchronous index clear; contents are kept
//   idx         current write index
//   rd_bus      flat read bus, bits [12k+11:12k] = operand k
module op2_bank
    import op2_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IN_W-1:0]     wdata,
    input  logic                clr_idx,
    output logic [IDX_W-1:0]    idx,
    output logic [OP_BUS_W-1:0] rd_bus
);
    logic [IN_W-1:0] regs [N_OPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            for (int k = 0; k < N_OPS; k++) regs[k] <= '0;
        end else if (clr_idx) begin
            idx <= '0;
        end else if (we) begin
            regs[idx] <= wdata;
            idx       <= idx + 1'b1;
        end
    end

    for (genvar k = 0; k < N_OPS; k++) begin : g_rd
        assign rd_bus[k*IN_W +: IN_W] = regs[k];
    end
endmodule

// File: rtl/op2_ctrl.sv
// op2_ctrl: collects 16 partial sums into the operand bank feeding the
// external 16-operand adder, waits SETTLE cycles, captures the sum and
// offers it downstream.
//   clk, rst_n  clock, async active-low reset
//   clr         synchronous abort (drops partial set and pending result)
//   bus         op2_ctrl_if.slave: word input and result output handshakes
//   op_data     operand bank to the adder
//   sum_in      adder result (combinational from op_data)
//   busy        high in WAIT and HOLD
// Parameter SETTLE (1..15): adder settle cycles before capture.
// Macro OP2_CTRL_DBLBUF_EN: adds a shadow bank that keeps accepting words
// during WAIT/HOLD; the banks swap at the result handshake.
//
// state | meaning
// FILL  | accepting words into the active bank
// WAIT  | operands complete, counting down adder settle time
// HOLD  | result registered, waiting for downstream handshake
module op2_ctrl
    import op2_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    op2_ctrl_if.slave           bus,
    output logic [OP_BUS_W-1:0] op_data,
    input  logic [SUM_W-1:0]    sum_in,
    output logic                busy
);
    localparam logic [3:0]       WCNT_LOAD = 4'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OPS - 1);

    op2_state_t       state;
    logic [3:0]       wcnt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [SUM_W-1:0] out_data_q;

    logic             xfer;
    logic             act_we;
    logic [IDX_W-1:0] act_idx;
    logic             shd_fill_done;
    logic             shd_full_nxt;

    assign xfer   = bus.in_valid && in_ready_q && !clr;
    assign act_we = xfer && (state == FILL);

`ifdef OP2_CTRL_DBLBUF_EN
    localparam logic DBL = 1'b1;

    // sel picks which physical bank is active (drives op_data)
    logic                sel;
    logic                shd_full;
    logic                shd_we;
    logic [IDX_W-1:0]    shd_idx;
    logic [IDX_W-1:0]    idx0, idx1;
    logic [OP_BUS_W-1:0] rd0, rd1;

    assign shd_we        = xfer && (state != FILL);
    assign act_idx       = sel ? idx1 : idx0;
    assign shd_idx       = sel ? idx0 : idx1;
    assign op_data       = sel ? rd1 : rd0;
    assign shd_fill_done = shd_we && (shd_idx == LAST_IDX);
    // a shadow write completing at the handshake edge still counts as full
    assign shd_full_nxt  = shd_full || shd_fill_done;

    op2_bank u_bank0 (
        .clk(clk), .rst_n(rst_n), .we(sel ? shd_we : act_we),
        .wdata(bus.in_data), .clr_idx(clr), .idx(idx0), .rd_bus(rd0)
    );
    op2_bank u_bank1 (
        .clk(clk), .rst_n(rst_n), .we(sel ? act_we : shd_we),
        .wdata(bus.in_data), .clr_idx(clr), .idx(idx1), .rd_bus(rd1)
    );

    // Swapping on every handshake is safe: the outgoing active bank has
    // wrapped to index 0, so it becomes an empty shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= 1'b0;
            shd_full <= 1'b0;
        end else if (clr) begin
            sel      <= 1'b0;
            shd_full <= 1'b0;
        end else if (state == HOLD && bus.out_ready) begin
            sel      <= ~sel;
            shd_full <= 1'b0;
        end else if (shd_fill_done) begin
            shd_full <= 1'b1;
        end
    end
`else
    localparam logic DBL = 1'b0;

    assign shd_fill_done = 1'b0;
    assign shd_full_nxt  = 1'b0;

    op2_bank u_bank0 (
        .clk(clk), .rst_n(rst_n), .we(act_we),
        .wdata(bus.in_data), .clr_idx(clr), .idx(act_idx), .rd_bus(op_data)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wcnt        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else if (clr) begin
            state       <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (act_we && act_idx == LAST_IDX) begin
                        state      <= WAIT;
                        wcnt       <= WCNT_LOAD;
                        in_ready_q <= DBL;
                        busy_q     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wcnt == '0) begin
                        state       <= HOLD;
                        out_data_q  <= sum_in;
                        out_valid_q <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                    if (shd_fill_done) in_ready_q <= 1'b0;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (shd_full_nxt) begin
                            state      <= WAIT;
                            wcnt       <= WCNT_LOAD;
                            in_ready_q <= 1'b0;
                        end else begin
                            state      <= FILL;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end else if (shd_fill_done) begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
endmodule

// File: doc/op2_ctrl.md
# op2_ctrl

Sequencing controller for the second-stage 16-operand adder. Accepts a serial stream of 12-bit first-stage partial sums over a valid/ready handshake and collects 16 of them into an operand register bank that drives the adder inputs. It then waits a programmable settle time for the combinational adder tree, captures the 16-bit result, and presents it downstream over a second valid/ready handshake. Sits between the first-stage adder outputs and the filter output register.

## Interface
- SETTLE, default 2: cycles allowed for the adder tree to settle before capture; legal range 1..15.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clr  in  1  synchronous abort: discards the partial bank and any pending result.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  controller can accept a word.
- in_data  in  12  partial sum, unsigned.
- op_data  out  192  operand bank to the adder; bits [12k+11:12k] = operand k, k = 0..15.
- sum_in  in  16  adder result, combinational from op_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  registered sum, unsigned.
- busy  out  1  high in WAIT and HOLD.

## Operation
- States: FILL, WAIT, HOLD. Reset and clr go to FILL.
- FILL: in_ready = 1. A transfer occurs when in_valid and in_ready are both high at a clock edge. The transfer writes in_data to operand idx, then increments idx (4-bit). The transfer at idx = 15 moves the state to WAIT, loads wcnt = SETTLE − 1, and wraps idx to 0.
- WAIT: in_ready = 0 (see Configuration). wcnt decrements each cycle. At the edge where wcnt = 0, sum_in is registered into out_data and the state moves to HOLD.
- HOLD: out_valid = 1, and out_data is stable until the handshake completes. Handshake (out_valid and out_ready high) returns to FILL.
- Operands are held unchanged through WAIT and HOLD. op_data is only written during FILL transfers.
- Arithmetic: 16 × 4095 = 65520 fits in 16 bits, so no overflow is possible and no saturation is needed.
- clr has priority over every other event at the same edge. It sets idx = 0, state = FILL, out_valid = 0, and discards a word presented at that edge. op_data and out_data keep their previous contents.
- Reset values: state FILL, idx 0, wcnt 0, in_ready 1, out_valid 0, out_data 0, op_data 0, busy 0.
- Reset asserted mid-fill or mid-hold returns immediately to these values. The pending result is lost.

## Timing
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from inputs.
- Last-word transfer at edge E, SETTLE = S: out_valid is high after edge E+S. sum_in is sampled at edge E+S, which gives the adder S full cycles to settle.
- Throughput without double buffering is one result per 16 + S + 1 cycles minimum (out_ready held high).
- Back-to-back operation: the handshake at edge H returns to FILL, with in_ready high after H. The first word of the next set can transfer at edge H+1.
- out_ready high while out_valid is low has no effect. in_valid while in_ready is low is ignored, and upstream must hold the word.

## Configuration
- OP2_CTRL_DBLBUF_EN defined: a second (shadow) operand bank is added. in_ready stays high in WAIT and HOLD until the shadow holds 16 words; shadow writes use their own index.
- When the HOLD handshake occurs with the shadow full, the banks swap and the state goes directly to WAIT (wcnt = SETTLE − 1). If the shadow is partly filled, the state returns to FILL and continues at the shadow index.
- clr empties both banks.
- Not defined: single bank; in_ready = 0 outside FILL.

## Structure
- Package op2_pkg holds:
  - constants N_OPS = 16, IN_W = 12, SUM_W = 16, IDX_W = 4;
  - the state enum (FILL, WAIT, HOLD);
  - the flat operand-bus width N_OPS × IN_W.
- Sub-module op2_bank: 16 × 12 register file with write-enable, 4-bit write index, flat read bus and clear-index. It is instantiated once, or twice under OP2_CTRL_DBLBUF_EN.
- The adder itself is instantiated alongside op2_ctrl at the enclosing level, not inside it.

## Test plan
- Reset, then feed words 1..16 with in_valid held high, SETTLE = 2 → in_ready low after the 16th edge; out_valid high 2 edges later; out_data = 136; op_data operand 5 = 6.
- Feed 16 × 4095, out_ready held low for 10 cycles → out_data = 65520 stable throughout, in_ready = 0; out_ready pulse → FILL, in_ready = 1 on the next cycle.
- Random in_valid gaps (50 %) over 16 words of value 100 → out_data = 1600; idx only advances on transfers.
- clr asserted after 7 words, then 16 × 1 → out_data = 16; the first 7 words do not contribute.
- rst_n asserted during HOLD → out_valid drops immediately; after release, out_data = 0 and in_ready = 1.
- With OP2_CTRL_DBLBUF_EN: two sets (all 1s, then all 2s) streamed without gaps, out_ready high → results 16 then 32; the second set is accepted during WAIT/HOLD of the first, with no in_ready low cycles.
